mem_block_bridge: RTL

Parametrised bridge that serves block-wide (cache-line) read/write requests from the processor core against a narrow, word-wide synchronous RAM, sequencing one word per clock. It sits between the core's block memory port and a single-port data RAM macro, and replaces fixed-width direct block memories. Block width, word width and address width are generic. Writes support a per-word mask. Responses use a valid/ready handshake so the core can stall.

---
 rtl/mem_bridge_pkg.sv | 28 ++
 rtl/mem_block_bridge_assembler.sv | 33 +++
 rtl/mem_block_bridge.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the block-to-word memory bridge: FSM states,
// default widths and the beat-count derivation used by every bridge file.
package mem_bridge_pkg;

  localparam int DEF_BLOCK_W = 256;
  localparam int DEF_WORD_W  = 32;
  localparam int DEF_ADDR_W  = 11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    RESP
  } bridgeState_t;

  function automatic int calcBeats(input int blockW, input int wordW);
    return blockW / wordW;
  endfunction

  // Beat index width; a single-beat block still carries a 1-bit index.
  function automatic int calcBeatW(input int blockW, input int wordW);
    int beats;
    beats = blockW / wordW;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_block_bridge_assembler.sv
// Word-slot register that gathers RAM read words into one block; cleared at
// the start of every request so a write acknowledge returns all zeros.
module block_assembler
  import mem_bridge_pkg::*;
#(
  parameter int BEATS  = DEF_BLOCK_W / DEF_WORD_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int BEAT_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    wrEn,
  input  logic [BEAT_W-1:0]       wrSlot,
  input  logic [WORD_W-1:0]       wrWord,
  output logic [BEATS*WORD_W-1:0] block
);

  logic [BEATS-1:0][WORD_W-1:0] slots;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots <= '0;
    end else if (clr) begin
      slots <= '0;
    end else if (wrEn) begin
      slots[wrSlot] <= wrWord;
    end
  end

  assign block = slots;

endmodule

// File: rtl/mem_block_bridge.sv
// Serves block-wide read/write requests against a word-wide synchronous RAM,
// one word per clock, with a valid/ready response the core may stall.
module mem_block_bridge
  import mem_bridge_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic                                          req_write,
  input  logic [ADDR_W-1:0]                             req_addr,
  input  logic [BLOCK_W-1:0]                            req_wdata,
  input  logic [calcBeats(BLOCK_W, WORD_W)-1:0]         req_wmask,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [BLOCK_W-1:0]                            rsp_rdata,
  output logic                                          ram_en,
  output logic                                          ram_we,
  output logic [ADDR_W+calcBeatW(BLOCK_W, WORD_W)-1:0]  ram_addr,
  output logic [WORD_W-1:0]                             ram_wdata,
  input  logic [WORD_W-1:0]                             ram_rdata
);

  localparam int BEATS  = calcBeats(BLOCK_W, WORD_W);
  localparam int BEAT_W = calcBeatW(BLOCK_W, WORD_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  bridgeState_t       state;
  logic [BEAT_W-1:0]  beat;
  logic [BEAT_W-1:0]  nextBeat;
  logic [ADDR_W-1:0]  blkAddr;
  logic [BLOCK_W-1:0] blkData;
  logic [BEATS-1:0]   blkMask;
  logic               accept;
  logic               capEn;
  logic [BEAT_W-1:0]  capSlot;

  assign accept   = (state == IDLE) && req_valid;
  assign nextBeat = beat + BEAT_W'(1);

  // Read data lags its address by one cycle, so the slot trails the issued beat.
  assign capEn   = ((state == READ) && (beat != '0)) || (state == DRAIN);
  assign capSlot = (state == DRAIN) ? LAST_BEAT : beat - BEAT_W'(1);

  always_ff @(posedge clock) begin
    if (accept) begin
      blkAddr <= req_addr;
      blkData <= req_wdata;
      blkMask <= req_wmask;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= req_write ? WRITE : READ;
            beat      <= '0;
            req_ready <= 1'b0;
            ram_en    <= 1'b1;
            ram_we    <= req_write & req_wmask[0];
            ram_addr  <= {req_addr, BEAT_W'(0)};
            ram_wdata <= req_wdata[WORD_W-1:0];
          end
        end
        WRITE: begin
          if (beat == LAST_BEAT) begin
            state     <= RESP;
            beat      <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            beat      <= nextBeat;
            ram_addr  <= {blkAddr, nextBeat};
            ram_wdata <= blkData[nextBeat*WORD_W +: WORD_W];
            ram_we    <= blkMask[nextBeat];
          end
        end
        READ: begin
          if (beat == LAST_BEAT) begin
            state  <= DRAIN;
            beat   <= '0;
            ram_en <= 1'b0;
          end else begin
            beat     <= nextBeat;
            ram_addr <= {blkAddr, nextBeat};
          end
        end
        DRAIN: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  block_assembler #(
    .BEATS (BEATS),
    .WORD_W(WORD_W),
    .BEAT_W(BEAT_W)
  ) uAssembler (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .wrEn  (capEn),
    .wrSlot(capSlot),
    .wrWord(ram_rdata),
    .block (rsp_rdata)
  );

endmodule
